// File: rtl/pipe_ctrl_pkg.sv
// Shared defaults and sizing helpers for the pipeline load-enable controller.
package pipe_ctrl_pkg;

    localparam int DEF_PIPELINE_STAGE = 5;
    localparam int DEF_STALL_CNT_W    = 16;

    // Bits needed to count 0..stages inclusive.
    function automatic int cnt_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_valid_stage.sv
// One valid flop of the pipeline: loads from the previous stage whenever it is
// empty or the stage after it is moving.
module pipe_valid_stage
    import pipe_ctrl_pkg::*;
(
    input  logic sys_clk,
    input  logic rstn,
    input  logic flush_i,
    input  logic prev_vld_i,
    input  logic next_en_i,
    output logic vld_o,
    output logic en_o,
    output logic load_o
);

    logic vld_q;
    logic vld_d;

    // en_o is the unmasked chain term; masking it here would break the
    // upstream chain during flush, so flush/reset only gate load_o.
    assign en_o   = !vld_q | next_en_i;
    assign load_o = en_o & !flush_i & rstn;
    assign vld_o  = vld_q;

    always_comb begin
        vld_d = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (load_o) begin
            vld_d = prev_vld_i;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

endmodule

// File: rtl/pipe_load_ctrl.sv
// Per-stage load enables and valid tracking for a register chain, with
// bubble collapse, flush, occupancy and a saturating stall counter.
module pipe_load_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PIPELINE_STAGE = DEF_PIPELINE_STAGE,
    parameter int CNT_WIDTH      = cnt_width(PIPELINE_STAGE),
    parameter int STALL_CNT_W    = DEF_STALL_CNT_W
) (
    input  logic                      sys_clk,
    input  logic                      rstn,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    input  logic                      flush_i,
    output logic [PIPELINE_STAGE-1:0] pipeLoad_en_o,
    output logic [PIPELINE_STAGE-1:0] stage_valid_o,
    output logic [CNT_WIDTH-1:0]      occupancy_o,
    output logic [STALL_CNT_W-1:0]    stall_cnt_o
);

    // Handshake: a token moves across an interface on a rising edge where
    // valid and ready are both high; valid never depends on ready at the same
    // interface, and flush or reset suppress both ends for that cycle.

    logic [PIPELINE_STAGE-1:0] vld;
    logic [PIPELINE_STAGE-1:0] en;
    logic [PIPELINE_STAGE-1:0] load;

    for (genvar s = 0; s < PIPELINE_STAGE; s++) begin : g_stage
        logic next_en;
        logic prev_vld;

        if (s == PIPELINE_STAGE - 1) begin : g_last
            assign next_en = out_ready_i;
        end else begin : g_mid
            assign next_en = en[s+1];
        end

        if (s == 0) begin : g_first
            assign prev_vld = in_valid_i;
        end else begin : g_rest
            assign prev_vld = vld[s-1];
        end

        pipe_valid_stage u_stage (
            .sys_clk    (sys_clk),
            .rstn       (rstn),
            .flush_i    (flush_i),
            .prev_vld_i (prev_vld),
            .next_en_i  (next_en),
            .vld_o      (vld[s]),
            .en_o       (en[s]),
            .load_o     (load[s])
        );
    end

    assign pipeLoad_en_o = load;
    assign in_ready_o    = en[0] & !flush_i & rstn;
    assign out_valid_o   = vld[PIPELINE_STAGE-1] & !flush_i & rstn;
    assign stage_valid_o = vld;

    logic [CNT_WIDTH-1:0] occ;

    always_comb begin
        occ = '0;
        for (int i = 0; i < PIPELINE_STAGE; i++) begin
            occ = occ + CNT_WIDTH'(vld[i]);
        end
    end

    assign occupancy_o = occ;

    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // Saturates at all-ones; flush deliberately leaves the count alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
